// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
//  Shared definitions for the Sim-AC instruction sequencer:
//   - opcode constants OP_ADD .. OP_HLT (3-bit opcode field of the instruction)
//   - FSM state encoding S_FETCH / S_DECODE / S_EXEC / S_HALT (2 bits)
//   - is_jump(op):      opcode drives the branch unit (JMP, JZ, JC)
//   - writes_flags(op): opcode loads Z/C from the ALU (ADD, SUB, LDA)
// -----------------------------------------------------------------------------
package seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_STA = 3'b011;
  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_JC  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  function automatic logic is_jump(input logic [2:0] op);
    return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
  endfunction

  // Jumps never write flags, so a flag update and a branch can never
  // coincide in one EXEC cycle.
  function automatic logic writes_flags(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/seq_flags.sv
// -----------------------------------------------------------------------------
// seq_flags
//  Z/C flag register with a shared write enable.
//  Ports:
//   clk_i   in  clock, rising edge
//   rst_ni  in  synchronous active-low reset, clears both flags
//   we_i    in  load z_i/c_i this cycle
//   z_i     in  next Z value
//   c_i     in  next C value
//   z_o     out registered Z flag
//   c_o     out registered C flag
// -----------------------------------------------------------------------------
module seq_flags (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic we_i,
  input  logic z_i,
  input  logic c_i,
  output logic z_o,
  output logic c_o
);

  logic z_q, z_d;
  logic c_q, c_d;

  always_comb begin
    z_d = z_q;
    c_d = c_q;
    if (we_i) begin
      z_d = z_i;
      c_d = c_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      z_q <= z_d;
      c_q <= c_d;
    end
  end

  assign z_o = z_q;
  assign c_o = c_q;

endmodule

// File: rtl/seq_ctrl.sv
// -----------------------------------------------------------------------------
// seq_ctrl
//  Instruction sequencer for the Sim-AC core. Owns the PC, instruction
//  register and (through seq_flags) the Z/C flags, and runs a
//  FETCH -> DECODE -> EXEC -> FETCH loop, with HLT parking the FSM in HALT
//  until reset. The external branch unit sees op/flags/ctrl_jmp and returns
//  its taken decision on branch_i within the same cycle.
//
//  Optional feature macro: SEQ_STATS_EN
//   defined   -> taken_cnt_o / not_taken_cnt_o saturating branch counters
//   undefined -> those ports and counters are absent
//
//  Ports:
//   clk_i            in   clock, rising edge
//   rst_ni           in   synchronous active-low reset
//   instr_i          in   {op[2:0], addr[ADDR_W-1:0]} from instruction memory
//   instr_valid_i    in   instr_i valid this cycle
//   fetch_req_o      out  fetch request, address on pc_o
//   pc_o             out  program counter
//   alu_z_i          in   ALU zero result for the current EXEC
//   alu_c_i          in   ALU carry result for the current EXEC
//   op_o             out  IR opcode (valid DECODE through EXEC)
//   flag_z_o         out  registered Z flag
//   flag_c_o         out  registered C flag
//   ctrl_jmp_o       out  EXEC of JMP/JZ/JC
//   branch_i         in   branch unit decision
//   halted_o         out  high in HALT
//   taken_cnt_o      out  taken-branch count (SEQ_STATS_EN)
//   not_taken_cnt_o  out  not-taken-branch count (SEQ_STATS_EN)
// -----------------------------------------------------------------------------
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W+2:0] instr_i,
  input  logic              instr_valid_i,
  output logic              fetch_req_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              alu_z_i,
  input  logic              alu_c_i,
  output logic [2:0]        op_o,
  output logic              flag_z_o,
  output logic              flag_c_o,
  output logic              ctrl_jmp_o,
  input  logic              branch_i,
  output logic              halted_o
`ifdef SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0]  taken_cnt_o,
  output logic [CNT_W-1:0]  not_taken_cnt_o
`endif
);

  localparam int IW = ADDR_W + 3;
  localparam logic [ADDR_W-1:0] PC_ONE  = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE = 1;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [IW-1:0]     ir_q, ir_d;

  logic [2:0]        ir_op;
  logic [ADDR_W-1:0] ir_addr;
  logic              in_exec;
  logic              jmp_exec;
  logic              take;
  logic              flags_we;

  assign ir_op    = ir_q[IW-1 -: 3];
  assign ir_addr  = ir_q[ADDR_W-1:0];
  assign in_exec  = (state_q == S_EXEC);
  assign jmp_exec = in_exec && is_jump(ir_op);
  // branch_i is only honoured while ctrl_jmp_o is asserted.
  assign take     = jmp_exec && branch_i;
  assign flags_we = in_exec && writes_flags(ir_op);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (instr_valid_i) begin
          ir_d    = instr_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (ir_op == OP_HLT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        pc_d    = take ? ir_addr : pc_q + PC_ONE;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  seq_flags u_flags (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .we_i   (flags_we),
    .z_i    (alu_z_i),
    .c_i    (alu_c_i),
    .z_o    (flag_z_o),
    .c_o    (flag_c_o)
  );

  assign fetch_req_o = (state_q == S_FETCH);
  assign pc_o        = pc_q;
  assign op_o        = ir_op;
  assign ctrl_jmp_o  = jmp_exec;
  assign halted_o    = (state_q == S_HALT);

`ifdef SEQ_STATS_EN
  logic [CNT_W-1:0] taken_q, taken_d;
  logic [CNT_W-1:0] ntaken_q, ntaken_d;

  always_comb begin
    taken_d  = taken_q;
    ntaken_d = ntaken_q;
    if (jmp_exec) begin
      if (branch_i) taken_d  = sat_inc(taken_q);
      else          ntaken_d = sat_inc(ntaken_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      taken_q  <= '0;
      ntaken_q <= '0;
    end else begin
      taken_q  <= taken_d;
      ntaken_q <= ntaken_d;
    end
  end

  assign taken_cnt_o     = taken_q;
  assign not_taken_cnt_o = ntaken_q;
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_ctrl
//  Directed bench for seq_ctrl. A behavioural stand-in for the branch unit
//  closes the op/flags/ctrl_jmp -> branch loop; memory is a single word the
//  stimulus tasks set before each fetch.
// -----------------------------------------------------------------------------
module tb_seq_ctrl;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] LDA = 3'b010;
  localparam logic [2:0] JMP = 3'b100;
  localparam logic [2:0] JZ  = 3'b101;
  localparam logic [2:0] JC  = 3'b110;
  localparam logic [2:0] HLT = 3'b111;

  logic              clk;
  logic              rst_ni;
  logic [ADDR_W+2:0] mem_word;
  logic              mem_rdy;
  logic              fetch_req;
  logic [ADDR_W-1:0] pc;
  logic              alu_z, alu_c;
  logic [2:0]        op;
  logic              fz, fc;
  logic              ctrl_jmp;
  logic              branch;
  logic              halted;
`ifdef SEQ_STATS_EN
  logic [CNT_W-1:0]  taken_cnt, not_taken_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  seq_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .instr_i       (mem_word),
    .instr_valid_i (mem_rdy),
    .fetch_req_o   (fetch_req),
    .pc_o          (pc),
    .alu_z_i       (alu_z),
    .alu_c_i       (alu_c),
    .op_o          (op),
    .flag_z_o      (fz),
    .flag_c_o      (fc),
    .ctrl_jmp_o    (ctrl_jmp),
    .branch_i      (branch),
    .halted_o      (halted)
`ifdef SEQ_STATS_EN
    ,
    .taken_cnt_o     (taken_cnt),
    .not_taken_cnt_o (not_taken_cnt)
`endif
  );

  // Branch unit stand-in: JMP always, JZ on Z, JC on C.
  always_comb begin
    branch = 1'b0;
    if (ctrl_jmp) begin
      case (op)
        JMP:     branch = 1'b1;
        JZ:      branch = fz;
        JC:      branch = fc;
        default: branch = 1'b0;
      endcase
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one instruction from FETCH back to FETCH (zero-wait memory).
  // Pure stimulus; the calling test does the comparisons.
  task automatic run_instr(input logic [2:0] o, input logic [4:0] a,
                           input logic z, input logic c,
                           output logic [2:0] dec_op, output logic exec_jmp);
    mem_word = {o, a};
    alu_z    = z;
    alu_c    = c;
    @(posedge clk); #1;
    dec_op = op;
    @(posedge clk); #1;
    exec_jmp = ctrl_jmp;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    mem_rdy = 1'b1;
    mem_word = '0;
    alu_z = 1'b0;
    alu_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({pc, fz, fc, ctrl_jmp, halted, fetch_req, op} !== {5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL reset_state: pc=%0h z=%b c=%b jmp=%b halt=%b req=%b op=%0d, expected pc=0 z=0 c=0 jmp=0 halt=0 req=1 op=0",
               pc, fz, fc, ctrl_jmp, halted, fetch_req, op);
    end
`ifdef SEQ_STATS_EN
    n_cmp++;
    if ({taken_cnt, not_taken_cnt} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_counters: taken=%0d not_taken=%0d, expected 0/0", taken_cnt, not_taken_cnt);
    end
`endif
    rst_ni = 1'b1;
  endtask

  task automatic test_straight_line();
    logic [2:0] d;
    logic j;
    run_instr(LDA, 5'h03, 1'b1, 1'b0, d, j);
    n_cmp++;
    if (d !== LDA || j !== 1'b0) begin
      n_err++;
      $display("FAIL lda_decode: op=%0d jmp=%b, expected op=2 jmp=0", d, j);
    end
    n_cmp++;
    if ({pc, fz, fc} !== {5'd1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL lda_result: pc=%0h z=%b c=%b, expected pc=1 z=1 c=0", pc, fz, fc);
    end
    run_instr(ADD, 5'h04, 1'b0, 1'b1, d, j);
    n_cmp++;
    if ({pc, fz, fc} !== {5'd2, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL add_result: pc=%0h z=%b c=%b, expected pc=2 z=0 c=1", pc, fz, fc);
    end
  endtask

  task automatic test_jmp();
    logic [2:0] d;
    logic j;
    // ALU inputs deliberately disagree with the flags: a jump must not load them.
    run_instr(JMP, 5'h1A, 1'b1, 1'b0, d, j);
    n_cmp++;
    if (j !== 1'b1) begin
      n_err++;
      $display("FAIL jmp_ctrl: ctrl_jmp=%b, expected 1", j);
    end
    n_cmp++;
    if ({pc, fz, fc, fetch_req} !== {5'h1A, 1'b0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL jmp_target: pc=%0h z=%b c=%b req=%b, expected pc=1a z=0 c=1 req=1", pc, fz, fc, fetch_req);
    end
  endtask

  task automatic test_cond_branch();
    logic [2:0] d;
    logic j;
    run_instr(JZ, 5'h05, 1'b1, 1'b0, d, j);
    n_cmp++;
    if ({pc, fz, fc, j} !== {5'h1B, 1'b0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL jz_not_taken: pc=%0h z=%b c=%b jmp=%b, expected pc=1b z=0 c=1 jmp=1", pc, fz, fc, j);
    end
    run_instr(LDA, 5'h00, 1'b1, 1'b0, d, j);
    run_instr(JZ, 5'h05, 1'b0, 1'b0, d, j);
    n_cmp++;
    if ({pc, fz, fc} !== {5'h05, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL jz_taken: pc=%0h z=%b c=%b, expected pc=05 z=1 c=0", pc, fz, fc);
    end
    run_instr(SUB, 5'h00, 1'b0, 1'b1, d, j);
    run_instr(JC, 5'h07, 1'b0, 1'b0, d, j);
    n_cmp++;
    if ({pc, fz, fc} !== {5'h07, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL jc_taken: pc=%0h z=%b c=%b, expected pc=07 z=0 c=1", pc, fz, fc);
    end
    run_instr(ADD, 5'h00, 1'b0, 1'b0, d, j);
    run_instr(JC, 5'h07, 1'b0, 1'b1, d, j);
    n_cmp++;
    if ({pc, fz, fc} !== {5'h09, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL jc_not_taken: pc=%0h z=%b c=%b, expected pc=09 z=0 c=0", pc, fz, fc);
    end
  endtask

  task automatic test_fetch_stall();
    logic [2:0] d;
    logic j;
    mem_rdy  = 1'b0;
    mem_word = {JMP, 5'h1F};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({fetch_req, pc} !== {1'b1, 5'h09}) begin
        n_err++;
        $display("FAIL stall_cycle%0d: req=%b pc=%0h, expected req=1 pc=09", i, fetch_req, pc);
      end
    end
    mem_rdy = 1'b1;
    run_instr(JMP, 5'h1F, 1'b0, 1'b0, d, j);
    n_cmp++;
    if (pc !== 5'h1F) begin
      n_err++;
      $display("FAIL stall_resume: pc=%0h, expected 1f", pc);
    end
  endtask

  task automatic test_pc_wrap();
    logic [2:0] d;
    logic j;
    run_instr(ADD, 5'h00, 1'b0, 1'b0, d, j);
    n_cmp++;
    if ({pc, j} !== {5'h00, 1'b0}) begin
      n_err++;
      $display("FAIL pc_wrap: pc=%0h jmp=%b, expected pc=0 jmp=0", pc, j);
    end
  endtask

  task automatic test_reset_in_exec();
    logic [2:0] d;
    logic j;
    run_instr(ADD, 5'h00, 1'b0, 1'b0, d, j);
    // JMP 0x10 at pc=1, reset lands on the EXEC edge.
    mem_word = {JMP, 5'h10};
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    n_cmp++;
    if ({pc, fetch_req, ctrl_jmp, halted} !== {5'h00, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_exec_pc: pc=%0h req=%b jmp=%b halt=%b, expected pc=0 req=1 jmp=0 halt=0",
               pc, fetch_req, ctrl_jmp, halted);
    end
    // LDA with both ALU flags high, reset on its EXEC edge.
    mem_word = {LDA, 5'h00};
    alu_z = 1'b1;
    alu_c = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    n_cmp++;
    if ({pc, fz, fc} !== {5'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_exec_flags: pc=%0h z=%b c=%b, expected pc=0 z=0 c=0", pc, fz, fc);
    end
  endtask

`ifdef SEQ_STATS_EN
  task automatic test_stats();
    logic [2:0] d;
    logic j;
    for (int i = 0; i < 5; i++) run_instr(JMP, 5'h00, 1'b0, 1'b0, d, j);
    run_instr(JZ, 5'h05, 1'b0, 1'b0, d, j);
    n_cmp++;
    if ({taken_cnt, not_taken_cnt, pc} !== {2'd3, 2'd1, 5'h01}) begin
      n_err++;
      $display("FAIL stats_counters: taken=%0d not_taken=%0d pc=%0h, expected 3/1 pc=01",
               taken_cnt, not_taken_cnt, pc);
    end
  endtask
`endif

  task automatic test_halt();
    logic [2:0] d;
    logic j;
    int bad;
    if (pc !== 5'h01) run_instr(ADD, 5'h00, 1'b0, 1'b0, d, j);
    mem_word = {HLT, 5'h0C};
    @(posedge clk); #1;
    n_cmp++;
    if (op !== HLT || halted !== 1'b0) begin
      n_err++;
      $display("FAIL hlt_decode: op=%0d halt=%b, expected op=7 halt=0", op, halted);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({halted, fetch_req, ctrl_jmp, pc} !== {1'b1, 1'b0, 1'b0, 5'h01}) begin
        n_err++;
        $display("FAIL halt_cycle%0d: halt=%b req=%b jmp=%b pc=%0h, expected halt=1 req=0 jmp=0 pc=01",
                 i, halted, fetch_req, ctrl_jmp, pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_jmp();
    test_cond_branch();
    test_fetch_stall();
    test_pc_wrap();
    test_reset_in_exec();
`ifdef SEQ_STATS_EN
    test_stats();
`endif
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
